ram_arb: RTL

RAM_ARB -- requirements
Module: ram_arb

---
 rtl/ram_arb_if.sv | 45 ++++
 rtl/ram_arb.sv | 108 ++++++++++
 2 files changed

// File: rtl/ram_arb_if.sv
// Bundle between two requesters, the RAM arbiter and a registered single-port RAM.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface ram_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  s0_req_valid;
  logic                  s0_req_ready;
  logic                  s0_req_we;
  logic [ADDR_WIDTH-1:0] s0_req_addr;
  logic [DATA_WIDTH-1:0] s0_req_data;
  logic                  s0_rsp_valid;
  logic [DATA_WIDTH-1:0] s0_rsp_data;

  logic                  s1_req_valid;
  logic                  s1_req_ready;
  logic                  s1_req_we;
  logic [ADDR_WIDTH-1:0] s1_req_addr;
  logic [DATA_WIDTH-1:0] s1_req_data;
  logic                  s1_rsp_valid;
  logic [DATA_WIDTH-1:0] s1_rsp_data;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport slave (
    input  s0_req_valid, s0_req_we, s0_req_addr, s0_req_data,
    input  s1_req_valid, s1_req_we, s1_req_addr, s1_req_data,
    input  ram_dout,
    output s0_req_ready, s0_rsp_valid, s0_rsp_data,
    output s1_req_ready, s1_rsp_valid, s1_rsp_data,
    output ram_we, ram_addr, ram_din
  );

  modport master (
    output s0_req_valid, s0_req_we, s0_req_addr, s0_req_data,
    output s1_req_valid, s1_req_we, s1_req_addr, s1_req_data,
    output ram_dout,
    input  s0_req_ready, s0_rsp_valid, s0_rsp_data,
    input  s1_req_ready, s1_rsp_valid, s1_rsp_data,
    input  ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_arb.sv
// Two-requester round-robin arbiter in front of a single-port RAM with a
// one-cycle registered read; optionally zero-fills the RAM after reset.
module ram_arb #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 10,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  output logic      init_done,
  ram_arb_if.slave  bus
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  localparam state_t                RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_RUN;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_fill_cnt;
  logic                  r_ptr;
  logic                  r_rsp0;
  logic                  r_rsp1;
  logic                  w_gnt0;
  logic                  w_gnt1;

  // State, fill counter, priority pointer and one-cycle response flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= RESET_STATE;
      r_fill_cnt <= {ADDR_WIDTH{1'b0}};
      r_ptr      <= 1'b0;
      r_rsp0     <= 1'b0;
      r_rsp1     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // the counter parks on the last address instead of wrapping
      if (r_state == ST_INIT && r_fill_cnt != LAST_ADDR) begin
        r_fill_cnt <= r_fill_cnt + ADDR_ONE;
      end else begin
        r_fill_cnt <= r_fill_cnt;
      end
      if (w_gnt0) begin
        r_ptr <= 1'b1;
      end else if (w_gnt1) begin
        r_ptr <= 1'b0;
      end else begin
        r_ptr <= r_ptr;
      end
      r_rsp0 <= w_gnt0;
      r_rsp1 <= w_gnt1;
    end
  end

  // Next-state, grant selection and RAM port drive
  always_comb begin
    w_next_state = r_state;
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    bus.ram_we   = 1'b0;
    bus.ram_addr = {ADDR_WIDTH{1'b0}};
    bus.ram_din  = {DATA_WIDTH{1'b0}};
    case (r_state)
      ST_INIT: begin
        bus.ram_we   = rst_n;
        bus.ram_addr = r_fill_cnt;
        if (r_fill_cnt == LAST_ADDR) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_INIT;
        end
      end
      ST_RUN: begin
        w_next_state = ST_RUN;
        // r_ptr names the requester that wins a tie
        w_gnt0 = rst_n & bus.s0_req_valid & (~bus.s1_req_valid | ~r_ptr);
        w_gnt1 = rst_n & bus.s1_req_valid & (~bus.s0_req_valid |  r_ptr);
        if (w_gnt0) begin
          bus.ram_we   = bus.s0_req_we;
          bus.ram_addr = bus.s0_req_addr;
          bus.ram_din  = bus.s0_req_data;
        end else if (w_gnt1) begin
          bus.ram_we   = bus.s1_req_we;
          bus.ram_addr = bus.s1_req_addr;
          bus.ram_din  = bus.s1_req_data;
        end else begin
          bus.ram_we   = 1'b0;
          bus.ram_addr = {ADDR_WIDTH{1'b0}};
          bus.ram_din  = {DATA_WIDTH{1'b0}};
        end
      end
      default: begin
        w_next_state = RESET_STATE;
      end
    endcase
  end

  assign init_done        = (r_state == ST_RUN);
  assign bus.s0_req_ready = w_gnt0;
  assign bus.s1_req_ready = w_gnt1;
  assign bus.s0_rsp_valid = r_rsp0;
  assign bus.s1_rsp_valid = r_rsp1;
  assign bus.s0_rsp_data  = r_rsp0 ? bus.ram_dout : {DATA_WIDTH{1'b0}};
  assign bus.s1_rsp_data  = r_rsp1 ? bus.ram_dout : {DATA_WIDTH{1'b0}};

endmodule
